unpack_s3_piso: RTL and testbench
=================================

Name: unpack_s3_piso

Overview:
- Parallel-in serial-out decoder for packed S3 polynomials; it is the inverse of the PACK_S3 SIPO packing used on the encapsulation side.
- It accepts packed bytes, each holding 5 base-3 coefficients, and emits ternary coefficients one per transfer, lowest power first.
- It feeds the decapsulation datapath: ternary multiplier and lift stage. It sits between the byte-wide key/ciphertext input buffer and the coefficient-serial arithmetic.
- One frame = N_BYTES bytes in, N_BYTES*5 + 1 coefficients out. The top coefficient is always 0.

Parameters:
N_BYTES, 140, packed bytes per frame ((n-1)/5 for n = 701)
IDX_W, 10, width of coefficient index counter (must hold N_BYTES*5)

Ports:
ex_clk  input  1  single clock; all state updates on rising edge
ovr_rst1  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse, begins a frame; ignored unless IDLE
byte_in  input  8  packed byte, value = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4
byte_valid  input  1  byte_in valid
byte_ready  output  1  block can accept a byte this cycle
trit_out  output  2  coefficient: 00 = 0, 01 = 1, 10 = 2 (i.e. -1); 11 never driven
trit_valid  output  1  trit_out / coef_idx valid
trit_ready  input  1  downstream accepts trit this cycle
coef_idx  output  IDX_W  index of coefficient currently on trit_out
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse after last coefficient transferred
err  output  1  sticky: a byte > 242 was received this frame

Behaviour:
- Reset (async, ovr_rst1 = 1) drives all outputs and internal state to 0: state = IDLE, byte_ready = 0, trit_valid = 0, trit_out = 0, coef_idx = 0, busy = 0, done = 0, err = 0.
- States: IDLE, LOAD, SHIFT, PAD, DONE.
- IDLE
  - start = 1 -> LOAD; busy = 1; coef_idx = 0; byte counter = 0; err cleared.
- LOAD
  - byte_ready = 1, trit_valid = 0.
  - On byte_valid & byte_ready: latch residue r = byte_in. If byte_in > 242, set r = byte_in - 243 and set err = 1.
  - Set digit counter = 0 and go to SHIFT.
  - Latency: byte accepted at edge k -> first trit valid in the cycle after edge k.
- SHIFT
  - trit_valid = 1, trit_out = r mod 3.
  - On trit_valid & trit_ready: r <= r div 3, coef_idx += 1, digit counter += 1.
  - After the 5th transfer: if byte counter = N_BYTES-1, go to PAD; else increment byte counter and go to LOAD.
  - byte_ready = 0 throughout SHIFT.
  - Throughput: 5 trits per 6 cycles when unstalled.
- PAD
  - trit_valid = 1, trit_out = 00, coef_idx = N_BYTES*5.
  - On transfer, go to DONE.
- DONE
  - done = 1 for exactly one cycle; busy = 0; go to IDLE.
  - err holds its value until the next start.
- Handshake rules:
  - While trit_valid = 1 and trit_ready = 0, trit_out and coef_idx hold stable. trit_valid never deasserts without a transfer.
  - byte_valid is ignored outside LOAD.
- r is 8 bits; after each div 3, r fits in 7 bits. The 5th digit is always < 3 because r ≤ 242.
- start while busy is ignored. Frame progress and counters are unaffected.
- Reset mid-frame: immediate return to IDLE. Partial data is discarded, no done pulse.
- start and reset asserted together: reset wins.
- A transfer in the same cycle as trit_ready deasserting next cycle: the new trit is presented and held.

Test Plan:
- Reset, start, 1-byte-effective check with byte 0x00 -> trits 0,0,0,0,0 at idx 0..4; then LOAD with byte_ready = 1.
- Byte 242 (0xF2) -> trits 2,2,2,2,2; err stays 0.
- Byte 106 (0x6A) -> trits 1,2,2,0,1; first trit_valid one cycle after the accepting edge.
- Byte 250 -> err = 1 (sticky through frame), decoded as 7 -> trits 1,2,0,0,0.
- Full frame of 140 bytes with random trit_ready backpressure:
  - exactly 701 transfers, idx 0..700, idx 700 = 00;
  - done pulses once;
  - output stable during stalls;
  - reference model matches every trit.
- Reset asserted during SHIFT of byte 37 -> all outputs 0 immediately. A new start then decodes from idx 0. A start pulse mid-frame has no effect.

Source files
------------

// File: rtl/unpack_s3_piso.sv
// unpack_s3_piso
// ---------------------------------------------------------------------------
// Parallel-in serial-out decoder for packed S3 polynomials. It is the inverse
// of the PACK_S3 SIPO packer used on the encapsulation side.
//
// Each input byte holds five base-3 coefficients:
//   byte = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4
// The block emits them one per transfer, lowest power first. One frame is
// N_BYTES bytes in and N_BYTES*5 + 1 coefficients out. The final (top)
// coefficient is always 0.
//
// The block sits between the byte-wide key/ciphertext input buffer and the
// coefficient-serial decapsulation arithmetic (ternary multiplier and lift).
//
// Ports
//   ex_clk      : single clock; all state updates on the rising edge
//   ovr_rst1    : asynchronous, active-high reset
//   start       : one-cycle pulse that begins a frame (ignored unless idle)
//   byte_in     : packed byte
//   byte_valid  : byte_in is valid
//   byte_ready  : block can accept a byte this cycle
//   trit_out    : coefficient code, 00 = 0, 01 = 1, 10 = 2 (-1)
//   trit_valid  : trit_out / coef_idx are valid
//   trit_ready  : downstream accepts the trit this cycle
//   coef_idx    : index of the coefficient currently on trit_out
//   busy        : high from start acceptance until the frame completes
//   done        : one-cycle pulse after the last coefficient is transferred
//   err         : sticky; a byte > 242 was received in this frame
// ---------------------------------------------------------------------------
module unpack_s3_piso #(
  parameter int N_BYTES = 140,
  parameter int IDX_W   = 10
) (
  input  logic             ex_clk,
  input  logic             ovr_rst1,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [1:0]       trit_out,
  output logic             trit_valid,
  input  logic             trit_ready,
  output logic [IDX_W-1:0] coef_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BYTE_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PAD,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // r holds the not-yet-emitted part of the current byte; after each
  // divide-by-3 it shrinks, so the fifth digit is always a legal trit.
  logic [7:0]        r;
  logic [2:0]        digit_cnt;
  logic [BYTE_W-1:0] byte_cnt;

  logic       byte_take;
  logic       trit_take;
  logic       last_digit;
  logic       last_byte;
  logic       byte_over;
  logic [7:0] byte_residue;
  logic [7:0] r_mod3;
  logic [7:0] r_div3;

  // Bytes above 242 cannot be produced by a valid packer. They are folded
  // back into range by subtracting 243 so the digit stream stays legal,
  // and the frame is flagged through err.
  always_comb begin
    byte_over    = (byte_in > 8'd242);
    byte_residue = byte_over ? (byte_in - 8'd243) : byte_in;
    r_mod3       = r % 8'd3;
    r_div3       = r / 8'd3;
    last_digit   = (digit_cnt == 3'd4);
    last_byte    = (byte_cnt == LAST_BYTE);
  end

  // Outputs are decoded purely from the state and the residue register, so
  // during a stall (valid high, ready low) they cannot move.
  always_comb begin
    byte_ready = 1'b0;
    trit_valid = 1'b0;
    trit_out   = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      SHIFT: begin
        trit_valid = 1'b1;
        trit_out   = r_mod3[1:0];
        busy       = 1'b1;
      end
      PAD: begin
        trit_valid = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_take = (state == LOAD) && byte_valid;
    trit_take = trit_valid && trit_ready;
  end

  // Next-state logic. A start pulse only matters in IDLE, so a stray start
  // mid-frame leaves the frame untouched.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (byte_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (trit_take && last_digit) state_nxt = last_byte ? PAD : LOAD;
      end
      PAD: begin
        if (trit_take) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ex_clk or posedge ovr_rst1) begin
    if (ovr_rst1) state <= IDLE;
    else          state <= state_nxt;
  end

  // Datapath registers: residue, digit and byte counters, coefficient index
  // and the sticky error flag. coef_idx naturally lands on N_BYTES*5 once the
  // last real digit has gone out, which is the index of the padding zero.
  always_ff @(posedge ex_clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      r         <= 8'd0;
      digit_cnt <= 3'd0;
      byte_cnt  <= '0;
      coef_idx  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            digit_cnt <= 3'd0;
            byte_cnt  <= '0;
            coef_idx  <= '0;
            err       <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_take) begin
            r         <= byte_residue;
            digit_cnt <= 3'd0;
            err       <= err | byte_over;
          end
        end
        SHIFT: begin
          if (trit_take) begin
            r         <= r_div3;
            digit_cnt <= digit_cnt + 3'd1;
            coef_idx  <= coef_idx + IDX_W'(1);
            if (last_digit && !last_byte) byte_cnt <= byte_cnt + BYTE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_s3_piso.sv
// tb_unpack_s3_piso
// Scoreboard bench for unpack_s3_piso: expected trits are pushed when a byte
// is accepted and popped when the DUT transfers a trit.
module tb_unpack_s3_piso;

  localparam int N_BYTES = 140;
  localparam int IDX_W   = 10;
  localparam int N_COEF  = N_BYTES * 5 + 1;

  logic             ex_clk = 1'b0;
  logic             ovr_rst1;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [1:0]       trit_out;
  logic             trit_valid;
  logic             trit_ready;
  logic [IDX_W-1:0] coef_idx;
  logic             busy;
  logic             done;
  logic             err;

  unpack_s3_piso #(.N_BYTES(N_BYTES), .IDX_W(IDX_W)) dut (
    .ex_clk     (ex_clk),
    .ovr_rst1   (ovr_rst1),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .trit_out   (trit_out),
    .trit_valid (trit_valid),
    .trit_ready (trit_ready),
    .coef_idx   (coef_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 ex_clk = ~ex_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]       frame_bytes [N_BYTES];
  logic [1:0]       exp_trit_q [$];
  logic [IDX_W-1:0] exp_idx_q [$];
  int               model_idx;

  // Reference decode of one byte into five trits, lowest power first.
  task automatic push_byte(input logic [7:0] b);
    int v;
    v = (b > 8'd242) ? int'(b) - 243 : int'(b);
    for (int d = 0; d < 5; d++) begin
      exp_trit_q.push_back(2'(v % 3));
      exp_idx_q.push_back(IDX_W'(model_idx));
      model_idx++;
      v = v / 3;
    end
  endtask

  task automatic fill_frame(input int max_val);
    for (int i = 0; i < N_BYTES; i++) frame_bytes[i] = 8'($urandom_range(max_val));
  endtask

  task automatic do_start();
    @(negedge ex_clk);
    start = 1'b1;
    @(negedge ex_clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || coef_idx !== '0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_state: busy=%b ready=%b idx=%0d err=%b, required 1 1 0 0",
               busy, byte_ready, coef_idx, err);
    end
  endtask

  // Runs one frame with random byte gaps and random trit_ready stalls.
  // abort_at >= 0 resets the DUT during SHIFT of that byte index.
  // mid_start_at >= 0 pulses start while that many bytes have been sent.
  task automatic run_frame(input int abort_at, input int mid_start_at, input int stall_pct);
    int         bytes_sent = 0;
    int         xfers      = 0;
    int         done_cnt   = 0;
    int         cycles     = 0;
    logic       finished   = 1'b0;
    logic       aborted    = 1'b0;
    logic       held       = 1'b0;
    logic       lat_chk    = 1'b0;
    logic       err_exp    = 1'b0;
    logic [1:0]       held_trit = 2'b00;
    logic [IDX_W-1:0] held_idx  = '0;
    logic [1:0]       et;
    logic [IDX_W-1:0] ei;

    model_idx = 0;
    exp_trit_q.delete();
    exp_idx_q.delete();
    do_start();

    while (!finished && cycles < 20000) begin
      @(negedge ex_clk);
      cycles++;

      if (lat_chk) begin
        vectors++;
        if (trit_valid !== 1'b1 || err !== err_exp) begin
          miscompares++;
          $display("[TB] FAIL byte_latency: valid=%b err=%b, required 1 %b", trit_valid, err, err_exp);
        end
        lat_chk = 1'b0;
      end

      if (abort_at >= 0 && bytes_sent == abort_at + 1 && trit_valid === 1'b1) begin
        ovr_rst1 = 1'b1;
        #1;
        vectors++;
        if ({byte_ready, trit_valid, trit_out, coef_idx, busy, done, err} !== '0) begin
          miscompares++;
          $display("[TB] FAIL reset_mid_frame: rdy=%b vld=%b trit=%0d idx=%0d busy=%b done=%b err=%b, required all 0",
                   byte_ready, trit_valid, trit_out, coef_idx, busy, done, err);
        end
        byte_valid = 1'b0;
        trit_ready = 1'b0;
        aborted    = 1'b1;
        finished   = 1'b1;
        break;
      end

      if (held) begin
        vectors++;
        if (trit_valid !== 1'b1 || trit_out !== held_trit || coef_idx !== held_idx) begin
          miscompares++;
          $display("[TB] FAIL stall_hold: vld=%b trit=%0d idx=%0d, required 1 %0d %0d",
                   trit_valid, trit_out, coef_idx, held_trit, held_idx);
        end
      end

      if (done === 1'b1) begin
        done_cnt++;
        vectors++;
        if (busy !== 1'b0 || err !== err_exp) begin
          miscompares++;
          $display("[TB] FAIL done_state: busy=%b err=%b, required 0 %b", busy, err, err_exp);
        end
        finished = 1'b1;
      end

      start = (mid_start_at >= 0 && bytes_sent == mid_start_at && !finished) ? 1'b1 : 1'b0;
      trit_ready = ($urandom_range(99) >= stall_pct);

      if (bytes_sent < N_BYTES && !finished) begin
        byte_valid = ($urandom_range(3) != 0);
        byte_in    = frame_bytes[bytes_sent];
      end else begin
        byte_valid = $urandom_range(1) == 1;
        byte_in    = 8'($urandom_range(255));
      end

      if (byte_valid && byte_ready === 1'b1 && bytes_sent < N_BYTES && !finished) begin
        push_byte(byte_in);
        if (byte_in > 8'd242) err_exp = 1'b1;
        bytes_sent++;
        lat_chk = 1'b1;
        if (bytes_sent == N_BYTES) begin
          exp_trit_q.push_back(2'b00);
          exp_idx_q.push_back(IDX_W'(N_BYTES * 5));
        end
      end

      if (trit_valid === 1'b1 && trit_ready) begin
        xfers++;
        vectors++;
        if (exp_trit_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_trit: trit=%0d idx=%0d, required none", trit_out, coef_idx);
        end else begin
          et = exp_trit_q.pop_front();
          ei = exp_idx_q.pop_front();
          if (trit_out !== et || coef_idx !== ei) begin
            miscompares++;
            $display("[TB] FAIL trit_data: trit=%0d idx=%0d, required %0d %0d", trit_out, coef_idx, et, ei);
          end
        end
        held = 1'b0;
      end else begin
        held      = (trit_valid === 1'b1);
        held_trit = trit_out;
        held_idx  = coef_idx;
      end
    end

    start      = 1'b0;
    byte_valid = 1'b0;

    if (aborted) begin
      // Hold reset across an edge together with start: reset must win.
      @(negedge ex_clk);
      start = 1'b1;
      @(negedge ex_clk);
      ovr_rst1 = 1'b0;
      start    = 1'b0;
      @(negedge ex_clk);
      vectors++;
      if (busy !== 1'b0 || byte_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_beats_start: busy=%b ready=%b, required 0 0", busy, byte_ready);
      end
    end else begin
      vectors++;
      if (!finished || xfers != N_COEF || exp_trit_q.size() != 0 || done_cnt != 1) begin
        miscompares++;
        $display("[TB] FAIL frame_totals: finished=%b xfers=%0d left=%0d done=%0d, required 1 %0d 0 1",
                 finished, xfers, exp_trit_q.size(), done_cnt, N_COEF);
      end
      @(negedge ex_clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0 || trit_valid !== 1'b0 || err !== err_exp) begin
        miscompares++;
        $display("[TB] FAIL after_done: done=%b busy=%b rdy=%b vld=%b err=%b, required 0 0 0 0 %b",
                 done, busy, byte_ready, trit_valid, err, err_exp);
      end
    end
  endtask

  task automatic test_reset();
    ovr_rst1   = 1'b1;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    trit_ready = 1'b0;
    repeat (3) @(negedge ex_clk);
    vectors++;
    if ({byte_ready, trit_valid, trit_out, coef_idx, busy, done, err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: rdy=%b vld=%b trit=%0d idx=%0d busy=%b done=%b err=%b, required all 0",
               byte_ready, trit_valid, trit_out, coef_idx, busy, done, err);
    end
    ovr_rst1 = 1'b0;
    @(negedge ex_clk);
  endtask

  // Bytes 0x00, 242 and 106 lead the frame; no byte exceeds 242.
  task automatic test_known_bytes();
    fill_frame(242);
    frame_bytes[0] = 8'h00;
    frame_bytes[1] = 8'd242;
    frame_bytes[2] = 8'd106;
    run_frame(-1, -1, 30);
  endtask

  // Byte 250 first sets err for the rest of the frame; a stray start mid-frame.
  task automatic test_err_and_mid_start();
    fill_frame(242);
    frame_bytes[0] = 8'd250;
    run_frame(-1, 10, 40);
  endtask

  task automatic test_reset_mid_frame();
    fill_frame(255);
    run_frame(37, -1, 20);
  endtask

  task automatic test_back_to_back();
    fill_frame(255);
    run_frame(-1, -1, 0);
    fill_frame(242);
    run_frame(-1, -1, 50);
  endtask

  initial begin
    test_reset();
    test_known_bytes();
    test_err_and_mid_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
